// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the coordinate width used by vga_sync
// and the graphics generator.
package vga_timing_pkg;

   localparam int H_DISPLAY = 640;
   localparam int H_FRONT   = 16;
   localparam int H_RETRACE = 96;
   localparam int H_BACK    = 48;
   localparam int V_DISPLAY = 480;
   localparam int V_FRONT   = 10;
   localparam int V_RETRACE = 2;
   localparam int V_BACK    = 33;
   localparam int CLK_DIV   = 2;

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;

   localparam int COORD_W = 10;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with enable; wrap flags the enabled step from MOD-1 back to 0.
module mod_counter #(
   parameter int MOD = 2,
   parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] q,
   output logic         wrap
);

   assign wrap = en && (q == W'(MOD - 1));

   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (wrap)
         q <= '0;
      else if (en)
         q <= q + 1'b1;
   end

endmodule

// File: rtl/vga_sync.sv
// VGA timing source: pixel-tick divider, 800x525 scan counters, registered syncs.
// Define VGA_FRAME_TICK_EN to add the frame_tick output (one-clk pulse on frame wrap).
import vga_timing_pkg::*;

module vga_sync #(
   parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
   parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
   parameter int H_RETRACE = vga_timing_pkg::H_RETRACE,
   parameter int H_BACK    = vga_timing_pkg::H_BACK,
   parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
   parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
   parameter int V_RETRACE = vga_timing_pkg::V_RETRACE,
   parameter int V_BACK    = vga_timing_pkg::V_BACK,
   parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV
) (
   input  logic               clk,
   input  logic               reset,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic               p_tick,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y
`ifdef VGA_FRAME_TICK_EN
   ,
   output logic               frame_tick
`endif
);

   localparam int LINE_LEN  = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
   localparam int FRAME_LEN = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;
   localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam int HS_START = H_DISPLAY + H_FRONT;
   localparam int HS_END   = H_DISPLAY + H_FRONT + H_RETRACE - 1;
   localparam int VS_START = V_DISPLAY + V_FRONT;
   localparam int VS_END   = V_DISPLAY + V_FRONT + V_RETRACE - 1;

   logic [DIV_W-1:0]   div_cnt;
   logic               div_wrap;
   logic               h_wrap;
   logic               v_wrap;
   logic [COORD_W-1:0] h_next;
   logic [COORD_W-1:0] v_next;

   mod_counter #(.MOD(CLK_DIV), .W(DIV_W)) u_div (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .q     (div_cnt),
      .wrap  (div_wrap)
   );

   mod_counter #(.MOD(LINE_LEN), .W(COORD_W)) u_h (
      .clk   (clk),
      .reset (reset),
      .en    (div_wrap),
      .q     (pixel_x),
      .wrap  (h_wrap)
   );

   mod_counter #(.MOD(FRAME_LEN), .W(COORD_W)) u_v (
      .clk   (clk),
      .reset (reset),
      .en    (h_wrap),
      .q     (pixel_y),
      .wrap  (v_wrap)
   );

   assign p_tick   = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign video_on = (pixel_x < COORD_W'(H_DISPLAY)) && (pixel_y < COORD_W'(V_DISPLAY));

   // Syncs are decoded from the values the counters take on this edge, so they
   // line up with pixel_x/pixel_y instead of lagging by one clock.
   always_comb begin
      h_next = pixel_x;
      v_next = pixel_y;
      if (h_wrap)
         h_next = '0;
      else if (p_tick)
         h_next = pixel_x + 1'b1;
      if (v_wrap)
         v_next = '0;
      else if (h_wrap)
         v_next = pixel_y + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         hsync <= !((h_next >= COORD_W'(HS_START)) && (h_next <= COORD_W'(HS_END)));
         vsync <= !((v_next >= COORD_W'(VS_START)) && (v_next <= COORD_W'(VS_END)));
      end
   end

`ifdef VGA_FRAME_TICK_EN
   always_ff @(posedge clk) begin
      if (reset)
         frame_tick <= 1'b0;
      else
         frame_tick <= v_wrap;
   end
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: a default-timing instance and a tiny-frame instance
// (CLK_DIV=1) checked every clock against closed-form expected scan positions.
module tb_vga_sync;

   logic       clk = 1'b0;
   logic       reset_f;
   logic       reset_s;

   logic       hsync_f, vsync_f, video_on_f, p_tick_f;
   logic [9:0] pixel_x_f, pixel_y_f;
   logic       hsync_s, vsync_s, video_on_s, p_tick_s;
   logic [9:0] pixel_x_s, pixel_y_s;
`ifdef VGA_FRAME_TICK_EN
   logic       frame_tick_f, frame_tick_s;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vga_sync dut_full (
      .clk        (clk),
      .reset      (reset_f),
      .hsync      (hsync_f),
      .vsync      (vsync_f),
      .video_on   (video_on_f),
      .p_tick     (p_tick_f),
      .pixel_x    (pixel_x_f),
      .pixel_y    (pixel_y_f)
`ifdef VGA_FRAME_TICK_EN
      ,
      .frame_tick (frame_tick_f)
`endif
   );

   // Small frame: 15 pixels x 8 lines, hsync low on x 10..12, vsync low on y 5..6.
   vga_sync #(
      .H_DISPLAY(8), .H_FRONT(2), .H_RETRACE(3), .H_BACK(2),
      .V_DISPLAY(4), .V_FRONT(1), .V_RETRACE(2), .V_BACK(1),
      .CLK_DIV(1)
   ) dut_small (
      .clk        (clk),
      .reset      (reset_s),
      .hsync      (hsync_s),
      .vsync      (vsync_s),
      .video_on   (video_on_s),
      .p_tick     (p_tick_s),
      .pixel_x    (pixel_x_s),
      .pixel_y    (pixel_y_s)
`ifdef VGA_FRAME_TICK_EN
      ,
      .frame_tick (frame_tick_s)
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Packed view {p_tick, hsync, vsync, video_on, y, x} of the state k clocks after reset release.
   function automatic logic [31:0] expFull(input int k);
      int pix, x, y;
      logic hs, vs, von, pt;
      pix = k / 2;
      x   = pix % 800;
      y   = (pix / 800) % 525;
      hs  = !(x >= 656 && x <= 751);
      vs  = !(y >= 490 && y <= 491);
      von = (x < 640) && (y < 480);
      pt  = (k % 2) == 1;
      return {8'd0, pt, hs, vs, von, 10'(y), 10'(x)};
   endfunction

   function automatic logic [31:0] expSmall(input int k);
      int x, y;
      logic hs, vs, von;
      x   = k % 15;
      y   = (k / 15) % 8;
      hs  = !(x >= 10 && x <= 12);
      vs  = !(y >= 5 && y <= 6);
      von = (x < 8) && (y < 4);
      return {8'd0, 1'b1, hs, vs, von, 10'(y), 10'(x)};
   endfunction

   task automatic applyStimulus(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         checkOutput($sformatf("full k=%0d", k),
                     {8'd0, p_tick_f, hsync_f, vsync_f, video_on_f, pixel_y_f, pixel_x_f},
                     expFull(k));
         checkOutput($sformatf("small k=%0d", k),
                     {8'd0, p_tick_s, hsync_s, vsync_s, video_on_s, pixel_y_s, pixel_x_s},
                     expSmall(k));
`ifdef VGA_FRAME_TICK_EN
         checkOutput($sformatf("full frame_tick k=%0d", k), {31'd0, frame_tick_f}, 32'd0);
         checkOutput($sformatf("small frame_tick k=%0d", k), {31'd0, frame_tick_s},
                     {31'd0, (k > 0) && (k % 120 == 0)});
`endif
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " pixel_x"},  {22'd0, pixel_x_f}, 32'd0);
      checkOutput({tag, " pixel_y"},  {22'd0, pixel_y_f}, 32'd0);
      checkOutput({tag, " hsync"},    {31'd0, hsync_f}, 32'd1);
      checkOutput({tag, " vsync"},    {31'd0, vsync_f}, 32'd1);
      checkOutput({tag, " video_on"}, {31'd0, video_on_f}, 32'd1);
      checkOutput({tag, " p_tick"},   {31'd0, p_tick_f}, 32'd0);
      checkOutput({tag, " small xy"}, {12'd0, pixel_y_s, pixel_x_s}, 32'd0);
      checkOutput({tag, " small p_tick"}, {31'd0, p_tick_s}, 32'd1);
   endtask

   initial begin
      reset_f = 1'b1;
      reset_s = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_f = 1'b0;
      reset_s = 1'b0;
      $display("[TB] reset released");
      checkResetState("rst");

      // Two full lines plus most of a third: line wrap, hsync window, blanking,
      // and ~38 wraps of the small frame including its vsync window.
      applyStimulus(4600);
      checkOutput("pre-reset full x", {22'd0, pixel_x_f}, 32'd700);
      checkOutput("pre-reset full y", {22'd0, pixel_y_f}, 32'd2);

      reset_f = 1'b1;
      reset_s = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset_f = 1'b0;
      reset_s = 1'b0;
      $display("[TB] mid-frame reset applied");
      checkResetState("midrst");
      applyStimulus(300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
